shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: STEP, 3, maximum shift distance applied per cycle.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous active-high reset.
REQ-006 Port: req0_valid / req1_valid  input  1  requester N has a shift request.
REQ-007 Port: req0_ready / req1_ready  output  1  requester N's request is accepted this cycle.
REQ-008 Port: req0_data / req1_data  input  WIDTH  operand.
REQ-009 Port: req0_amt / req1_amt  input  5  shift amount, 0-31.
REQ-010 Port: req0_op / req1_op  input  2  op: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
REQ-011 Port: resp_valid  output  1  result available.
REQ-012 Port: resp_ready  input  1  consumer accepts the result.
REQ-013 Port: resp_data  output  WIDTH  shifted result.
REQ-014 Port: resp_id  output  1  index of the requester that owns the result.
REQ-015 Port: resp_err  output  1  set when the op was illegal.
REQ-016 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, SHIFT, DONE.
REQ-018 Grant rule in IDLE:
  - one valid requester: that requester is granted;
  - both valid: the requester not granted last is granted (round-robin).
REQ-019 reqN_ready is asserted combinationally only in IDLE and only for the granted N; at most one ready is high per cycle.
REQ-020 On handshake (reqN_valid & reqN_ready at the edge):
  - data, amt, op and id are captured;
  - the last-grant pointer is set to N.
REQ-021 After the handshake, the next state is:
  - DONE if amt==0 or op==11;
  - SHIFT otherwise.
REQ-022 SHIFT, each cycle:
  - shift the working register by s = min(remaining, STEP) using the captured op;
  - remaining -= s;
  - go to DONE when remaining reaches 0.
REQ-023 Fill rules:
  - SLL fills vacated bits with 0;
  - SRL fills with 0;
  - SRA fills with the operand's original bit WIDTH-1.
REQ-024 SHIFT occupancy is exactly ceil(amt/STEP) cycles, so resp_valid rises ceil(amt/STEP)+1 edges after the handshake edge (1 edge when amt==0).
REQ-025 Illegal op (11): resp_data equals the unmodified operand and resp_err=1; amt is ignored.
REQ-026 DONE:
  - resp_valid=1;
  - resp_data, resp_id and resp_err are held stable until resp_ready=1;
  - on that edge, go to IDLE.
REQ-027 No new request is accepted in SHIFT or DONE; requests arriving then wait with valid high and are arbitrated on return to IDLE.
REQ-028 Back-to-back throughput: a new grant is possible in the cycle after the resp handshake, not in the same cycle.
REQ-029 Requester inputs sampled outside the handshake edge have no effect.
REQ-030 resp_valid, resp_err and resp_id are 0 in IDLE and SHIFT.

Reset
REQ-031 While reset is high, regardless of clock:
  - state = IDLE;
  - working register, remaining count, resp_data, resp_id and resp_err = 0;
  - resp_valid = 0 and busy = 0;
  - last-grant pointer set so that req0 wins the first contention.
REQ-032 Reset asserted mid-SHIFT or mid-DONE aborts the operation; no response is produced after reset deasserts.

Verification
REQ-033 req0 SRA, data 0xE0000000, amt 3 -> resp_data 0xFC000000, resp_id 0, resp_valid 2 edges after handshake.
REQ-034 req1 SLL, data 0xE0000000, amt 3 -> resp_data 0x00000000; SRL, data 0x80000000, amt 31 -> 0x00000001 after 11 SHIFT cycles.
REQ-035 Both requesters valid continuously from reset, resp_ready=1 -> grants alternate 0,1,0,1; resp_id follows the same order.
REQ-036 amt=0, data 0x12345678 -> resp_data 0x12345678 one edge after handshake; op=11 -> same data with resp_err=1.
REQ-037 resp_ready held 0 for 5 cycles in DONE -> resp_* stable, both ready low, busy=1.
REQ-038 Reset pulsed during SHIFT of an amt=31 request -> all outputs 0 immediately, no resp_valid afterwards, next request served normally.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester round-robin barrel-free shifter: a granted operand is shifted
// by at most STEP bits per cycle, and the result is held until the consumer accepts it.
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [4:0]       req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [4:0]       req1_amt,
  input  logic [1:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             resp_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_work;
  logic [4:0]       r_rem;
  logic [1:0]       r_op;
  logic             r_id, r_err, r_last;

  logic             w_hs, w_sel;
  logic [WIDTH-1:0] w_data, w_shifted;
  logic [4:0]       w_amt, w_step;
  logic [1:0]       w_op;

  // r_last names the requester granted most recently; the other one wins a tie.
  assign req0_ready = (r_state == IDLE) & req0_valid & (~req1_valid | r_last);
  assign req1_ready = (r_state == IDLE) & req1_valid & (~req0_valid | ~r_last);

  assign w_hs   = req0_ready | req1_ready;
  assign w_sel  = req1_ready;
  assign w_data = w_sel ? req1_data : req0_data;
  assign w_amt  = w_sel ? req1_amt  : req0_amt;
  assign w_op   = w_sel ? req1_op   : req0_op;

  assign w_step = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;

  // Arithmetic shifts keep the MSB intact, so each partial step refills with the original sign.
  always_comb begin
    w_shifted = r_work;
    case (r_op)
      2'b00:   w_shifted = r_work << w_step;
      2'b01:   w_shifted = r_work >> w_step;
      2'b10:   w_shifted = $signed(r_work) >>> w_step;
      default: w_shifted = r_work;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = ((w_amt == '0) || (w_op == 2'b11)) ? DONE : SHIFT;
      SHIFT:   if (r_rem <= STEP_AMT) w_next = DONE;
      DONE:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_rem   <= '0;
      r_op    <= '0;
      r_id    <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_hs) begin
        r_work <= w_data;
        r_rem  <= (w_op == 2'b11) ? 5'd0 : w_amt;
        r_op   <= w_op;
        r_id   <= w_sel;
        r_err  <= (w_op == 2'b11);
        r_last <= w_sel;
      end else if (r_state == SHIFT) begin
        r_work <= w_shifted;
        r_rem  <= r_rem - w_step;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign resp_valid = (r_state == DONE);
  assign resp_id    = r_id & resp_valid;
  assign resp_err   = r_err & resp_valid;
  assign resp_data  = r_work;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: fixed vector table, arbitration/reset sequences,
// and random requests checked against an operator-level reference model.
module tb_shift_arbiter;

  localparam int W    = 32;
  localparam int STEP = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_data, req1_data;
  logic [4:0]    req0_amt, req1_amt;
  logic [1:0]    req0_op, req1_op;
  logic          resp_valid, resp_ready;
  logic [W-1:0]  resp_data;
  logic          resp_id, resp_err, busy;

  int n_pass = 0;
  int n_tot  = 0;

  shift_arbiter #(.WIDTH(W), .STEP(STEP)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] d;
    int          a;
    logic [1:0]  op;
    logic [31:0] exp_d;
    logic        exp_err;
    int          exp_lat;
    int          hold;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] model_data(input logic [31:0] d, input int a, input logic [1:0] op);
    case (op)
      2'd0:    return d << a;
      2'd1:    return d >> a;
      2'd2:    return 32'($signed(d) >>> a);
      default: return d;
    endcase
  endfunction

  function automatic int model_lat(input int a, input logic [1:0] op);
    if (a == 0 || op == 2'd3) return 1;
    return (a + STEP - 1) / STEP + 1;
  endfunction

  task automatic run_one(input int id, input logic [31:0] d, input int a, input logic [1:0] op,
                         input logic [31:0] exp_d, input logic exp_err, input int exp_lat,
                         input int hold, input string tag);
    int n;
    logic [31:0] snap;
    @(negedge clk);
    resp_ready = 1'b0;
    req0_valid = (id == 0);
    req1_valid = (id == 1);
    req0_data = (id == 0) ? d : $urandom;
    req1_data = (id == 1) ? d : $urandom;
    req0_amt  = (id == 0) ? 5'(a) : 5'($urandom);
    req1_amt  = (id == 1) ? 5'(a) : 5'($urandom);
    req0_op   = (id == 0) ? op : 2'($urandom);
    req1_op   = (id == 1) ? op : 2'($urandom);
    #1;
    chk({tag, " ready"}, {30'd0, req1_ready, req0_ready}, (id == 1) ? 32'd2 : 32'd1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = $urandom; req1_data = $urandom;
    req0_amt = 5'($urandom); req1_amt = 5'($urandom);
    req0_op = 2'($urandom); req1_op = 2'($urandom);
    #1;
    while (!resp_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " data"}, resp_data, exp_d);
    chk({tag, " id"}, {31'd0, resp_id}, 32'(id));
    chk({tag, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
    snap = resp_data;
    for (int h = 0; h < hold; h++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk({tag, " hold ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
      chk({tag, " hold valid/busy"}, {30'd0, resp_valid, busy}, 32'd3);
      chk({tag, " hold data"}, resp_data, snap);
      chk({tag, " hold id/err"}, {30'd0, resp_id, resp_err}, {30'd0, 1'(id), exp_err});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk({tag, " release"}, {30'd0, resp_valid, busy}, 32'd0);
  endtask

  initial begin
    int k, id, a, hold, seen;
    logic [31:0] d;
    logic [1:0] op;

    tbl[0] = '{0, 32'hE0000000,  3, 2'd2, 32'hFC000000, 1'b0,  2, 5};
    tbl[1] = '{1, 32'hE0000000,  3, 2'd0, 32'h00000000, 1'b0,  2, 0};
    tbl[2] = '{1, 32'h80000000, 31, 2'd1, 32'h00000001, 1'b0, 12, 1};
    tbl[3] = '{0, 32'h12345678,  0, 2'd0, 32'h12345678, 1'b0,  1, 0};
    tbl[4] = '{0, 32'h12345678,  5, 2'd3, 32'h12345678, 1'b1,  1, 2};
    tbl[5] = '{1, 32'h80000000, 31, 2'd2, 32'hFFFFFFFF, 1'b0, 12, 0};
    tbl[6] = '{0, 32'h0000F0F0,  4, 2'd0, 32'h000F0F00, 1'b0,  3, 0};
    tbl[7] = '{1, 32'h7FFFFFFF,  1, 2'd2, 32'h3FFFFFFF, 1'b0,  2, 0};

    reset = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; req0_amt = '0; req1_amt = '0; req0_op = '0; req1_op = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset outputs", {27'd0, resp_valid, resp_id, resp_err, busy, req0_ready}, 32'd0);
    chk("reset data", resp_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Round-robin from reset: both valid, consumer always ready.
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 32'hAAAA0000; req1_data = 32'h0000BBBB;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      #1;
      while (!(req0_ready | req1_ready) && k < 10) begin
        @(negedge clk);
        #1;
        k++;
      end
      chk("arb grant", {30'd0, req1_ready, req0_ready}, (i % 2 == 1) ? 32'd2 : 32'd1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("arb resp", {30'd0, resp_valid, resp_id}, (i % 2 == 1) ? 32'd3 : 32'd2);
      chk("arb data", resp_data, (i % 2 == 1) ? 32'h0000BBBB : 32'hAAAA0000);
      chk("arb no ready in done", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;

    foreach (tbl[i])
      run_one(tbl[i].id, tbl[i].d, tbl[i].a, tbl[i].op, tbl[i].exp_d, tbl[i].exp_err,
              tbl[i].exp_lat, tbl[i].hold, $sformatf("vec%0d", i));

    // Reset in the middle of a long shift.
    @(negedge clk);
    req0_valid = 1'b1; req0_amt = 5'd31; req0_op = 2'd1; req0_data = 32'h80000000;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset flags", {28'd0, resp_valid, resp_id, resp_err, busy}, 32'd0);
    chk("midreset data", resp_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid || busy) seen++;
    end
    chk("no resp after reset", 32'(seen), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post-reset priority", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    run_one(1, 32'h0F0F0F0F, 8, 2'd0, 32'h0F0F0F00, 1'b0, 4, 0, "post-reset");

    for (int r = 0; r < 40; r++) begin
      id = int'($urandom_range(0, 1));
      d = $urandom;
      a = int'($urandom_range(0, 31));
      op = 2'($urandom_range(0, 3));
      hold = int'($urandom_range(0, 2));
      run_one(id, d, a, op, model_data(d, a, op), (op == 2'd3), model_lat(a, op), hold,
              $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
